// File: rtl/axi_sram_slave.sv
// -----------------------------------------------------------------------------
// axi_sram_slave
//
// AXI4 single-beat responder backed by a word-organised SRAM. It terminates
// the io_master_* bus of the core's fetch/LSU interface so the NPC can be
// simulated without the SoC model. Read and write channels run as independent
// FSMs with programmable response latency. Accesses outside the SRAM window,
// or with a non-zero burst length, get DECERR.
//
// Parameters
//   BASE_ADDR : byte address of word 0
//   DEPTH     : SRAM size in 32-bit words (power of 2)
//   RD_LAT    : extra wait cycles between AR handshake and rvalid (0..15)
//   WR_LAT    : extra wait cycles between W handshake and bvalid (0..15)
//
// Ports
//   clock, reset            : single clock, synchronous active-high reset
//   io_slave_aw*            : write address channel (awlen must be 0)
//   io_slave_w*             : write data channel, lanes selected by wstrb
//   io_slave_b*             : write response (00 OKAY, 11 DECERR), bid = awid
//   io_slave_ar*            : read address channel (arlen must be 0)
//   io_slave_r*             : read response, rdata = word at araddr[31:2]
//                             (0 on DECERR), rlast = rvalid, rid = arid
//
// Timing
//   An AR handshake at edge N gives rvalid after edge N+1+RD_LAT; a W
//   handshake at edge K gives bvalid after edge K+1+WR_LAT. The extra cycle is
//   the registered SRAM read (and its matching slot on the write side).
//   All outputs read 0 while reset is high.
// -----------------------------------------------------------------------------
module axi_sram_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          DEPTH     = 4096,
  parameter int          RD_LAT    = 1,
  parameter int          WR_LAT    = 1
) (
  input  logic        clock,
  input  logic        reset,

  output logic        io_slave_awready,
  input  logic        io_slave_awvalid,
  input  logic [31:0] io_slave_awaddr,
  input  logic [3:0]  io_slave_awid,
  input  logic [7:0]  io_slave_awlen,
  input  logic [2:0]  io_slave_awsize,
  input  logic [1:0]  io_slave_awburst,

  output logic        io_slave_wready,
  input  logic        io_slave_wvalid,
  input  logic [31:0] io_slave_wdata,
  input  logic [3:0]  io_slave_wstrb,
  input  logic        io_slave_wlast,

  input  logic        io_slave_bready,
  output logic        io_slave_bvalid,
  output logic [1:0]  io_slave_bresp,
  output logic [3:0]  io_slave_bid,

  output logic        io_slave_arready,
  input  logic        io_slave_arvalid,
  input  logic [31:0] io_slave_araddr,
  input  logic [3:0]  io_slave_arid,
  input  logic [7:0]  io_slave_arlen,
  input  logic [2:0]  io_slave_arsize,
  input  logic [1:0]  io_slave_arburst,

  input  logic        io_slave_rready,
  output logic        io_slave_rvalid,
  output logic [1:0]  io_slave_rresp,
  output logic [31:0] io_slave_rdata,
  output logic        io_slave_rlast,
  output logic [3:0]  io_slave_rid
);

  localparam int          IDX_W    = $clog2(DEPTH);
  // One past the last byte of the window, in 33 bits so a window that ends
  // at the top of the address space does not wrap.
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [31:0]      ar_off;
  logic [31:0]      aw_off;
  logic             ar_hit;
  logic             aw_hit;

  assign ar_off = io_slave_araddr - BASE_ADDR;
  assign aw_off = io_slave_awaddr - BASE_ADDR;

  assign ar_hit = ({1'b0, io_slave_araddr} >= {1'b0, BASE_ADDR}) &&
                  ({1'b0, io_slave_araddr} <  END_ADDR) &&
                  (io_slave_arlen == 8'd0);
  assign aw_hit = ({1'b0, io_slave_awaddr} >= {1'b0, BASE_ADDR}) &&
                  ({1'b0, io_slave_awaddr} <  END_ADDR) &&
                  (io_slave_awlen == 8'd0);

  // Fields that carry no information for a single-beat word slave.
  logic unused_inputs;
  assign unused_inputs = ^{io_slave_awsize, io_slave_awburst, io_slave_wlast,
                           io_slave_arsize, io_slave_arburst,
                           ar_off[1:0], ar_off[31:IDX_W+2],
                           aw_off[1:0], aw_off[31:IDX_W+2]};

  // ---------------------------------------------------------------------------
  // Read channel FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } r_state_t;

  r_state_t         r_state_reg, r_state_next;
  logic [3:0]       r_cnt_reg, r_cnt_next;
  logic [IDX_W-1:0] r_idx_reg;
  logic             r_hit_reg;
  logic [3:0]       r_id_reg;
  logic             ar_hs;
  logic             rd_capture;

  assign ar_hs = io_slave_arvalid && (r_state_reg == R_IDLE);

  always_comb begin
    r_state_next = r_state_reg;
    r_cnt_next   = r_cnt_reg;
    rd_capture   = 1'b0;
    case (r_state_reg)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_next = R_WAIT;
          r_cnt_next   = 4'(RD_LAT);
        end
      end
      R_WAIT: begin
        // The SRAM word is captured on the edge that enters R_RESP, so a
        // write committing on that same edge is not seen (read-first).
        if (r_cnt_reg == 4'd0) begin
          r_state_next = R_RESP;
          rd_capture   = 1'b1;
        end else begin
          r_cnt_next = r_cnt_reg - 4'd1;
        end
      end
      R_RESP: begin
        if (io_slave_rready) begin
          r_state_next = R_IDLE;
        end
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state_reg <= R_IDLE;
      r_cnt_reg   <= 4'd0;
      r_hit_reg   <= 1'b0;
      r_id_reg    <= 4'd0;
      r_idx_reg   <= '0;
    end else begin
      r_state_reg <= r_state_next;
      r_cnt_reg   <= r_cnt_next;
      if (ar_hs) begin
        r_idx_reg <= ar_off[IDX_W+1:2];
        r_hit_reg <= ar_hit;
        r_id_reg  <= io_slave_arid;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Write channel FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_WAIT = 2'd2,
    W_RESP = 2'd3
  } w_state_t;

  w_state_t         w_state_reg, w_state_next;
  logic [3:0]       w_cnt_reg, w_cnt_next;
  logic [IDX_W-1:0] w_idx_reg;
  logic             w_hit_reg;
  logic [3:0]       w_id_reg;
  logic             aw_hs;
  logic             wr_commit;

  assign aw_hs     = io_slave_awvalid && (w_state_reg == W_IDLE);
  assign wr_commit = io_slave_wvalid && (w_state_reg == W_DATA) && !reset;

  always_comb begin
    w_state_next = w_state_reg;
    w_cnt_next   = w_cnt_reg;
    case (w_state_reg)
      W_IDLE: begin
        if (aw_hs) begin
          w_state_next = W_DATA;
        end
      end
      W_DATA: begin
        if (io_slave_wvalid) begin
          w_state_next = W_WAIT;
          w_cnt_next   = 4'(WR_LAT);
        end
      end
      W_WAIT: begin
        if (w_cnt_reg == 4'd0) begin
          w_state_next = W_RESP;
        end else begin
          w_cnt_next = w_cnt_reg - 4'd1;
        end
      end
      W_RESP: begin
        if (io_slave_bready) begin
          w_state_next = W_IDLE;
        end
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      w_state_reg <= W_IDLE;
      w_cnt_reg   <= 4'd0;
      w_hit_reg   <= 1'b0;
      w_id_reg    <= 4'd0;
      w_idx_reg   <= '0;
    end else begin
      w_state_reg <= w_state_next;
      w_cnt_reg   <= w_cnt_next;
      if (aw_hs) begin
        w_idx_reg <= aw_off[IDX_W+1:2];
        w_hit_reg <= aw_hit;
        w_id_reg  <= io_slave_awid;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // SRAM: one byte-wide array per lane so each lane maps onto a plain
  // single-write-port block RAM with a registered read. Contents are not
  // touched by reset.
  // ---------------------------------------------------------------------------
  logic [31:0] rd_word;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] lane_q;

      always_ff @(posedge clock) begin
        if (wr_commit && w_hit_reg && io_slave_wstrb[gi]) begin
          lane_mem[w_idx_reg] <= io_slave_wdata[8*gi +: 8];
        end
        if (rd_capture) begin
          lane_q <= lane_mem[r_idx_reg];
        end
      end

      assign rd_word[8*gi +: 8] = lane_q;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Outputs: decoded from state so they are stable while waiting for the
  // master, and forced low while reset is held.
  // ---------------------------------------------------------------------------
  assign io_slave_arready = !reset && (r_state_reg == R_IDLE);
  assign io_slave_rvalid  = !reset && (r_state_reg == R_RESP);
  assign io_slave_rlast   = io_slave_rvalid;
  assign io_slave_rresp   = (io_slave_rvalid && !r_hit_reg) ? RESP_DECERR : RESP_OKAY;
  assign io_slave_rdata   = (io_slave_rvalid && r_hit_reg) ? rd_word : 32'd0;
  assign io_slave_rid     = io_slave_rvalid ? r_id_reg : 4'd0;

  assign io_slave_awready = !reset && (w_state_reg == W_IDLE);
  assign io_slave_wready  = !reset && (w_state_reg == W_DATA);
  assign io_slave_bvalid  = !reset && (w_state_reg == W_RESP);
  assign io_slave_bresp   = (io_slave_bvalid && !w_hit_reg) ? RESP_DECERR : RESP_OKAY;
  assign io_slave_bid     = io_slave_bvalid ? w_id_reg : 4'd0;

endmodule

// File: tb/tb_axi_sram_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_sram_slave
//
// Directed bench for axi_sram_slave. Stimulus tasks push the expected R/B
// response into a queue when a transaction is issued; a monitor pops and
// compares whenever a response handshake is presented.
// -----------------------------------------------------------------------------
module tb_axi_sram_slave;

  localparam int          DEPTH  = 4096;
  localparam int          RD_LAT = 1;
  localparam int          WR_LAT = 1;
  localparam logic [31:0] BASE   = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        awready, awvalid;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wready, wvalid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bready, bvalid;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        arready, arvalid;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rready, rvalid;
  logic [1:0]  rresp;
  logic [31:0] rdata;
  logic        rlast;
  logic [3:0]  rid;

  always #5 clock = ~clock;

  axi_sram_slave #(
    .BASE_ADDR(BASE),
    .DEPTH    (DEPTH),
    .RD_LAT   (RD_LAT),
    .WR_LAT   (WR_LAT)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .io_slave_awready(awready),
    .io_slave_awvalid(awvalid),
    .io_slave_awaddr (awaddr),
    .io_slave_awid   (awid),
    .io_slave_awlen  (awlen),
    .io_slave_awsize (awsize),
    .io_slave_awburst(awburst),
    .io_slave_wready (wready),
    .io_slave_wvalid (wvalid),
    .io_slave_wdata  (wdata),
    .io_slave_wstrb  (wstrb),
    .io_slave_wlast  (wlast),
    .io_slave_bready (bready),
    .io_slave_bvalid (bvalid),
    .io_slave_bresp  (bresp),
    .io_slave_bid    (bid),
    .io_slave_arready(arready),
    .io_slave_arvalid(arvalid),
    .io_slave_araddr (araddr),
    .io_slave_arid   (arid),
    .io_slave_arlen  (arlen),
    .io_slave_arsize (arsize),
    .io_slave_arburst(arburst),
    .io_slave_rready (rready),
    .io_slave_rvalid (rvalid),
    .io_slave_rresp  (rresp),
    .io_slave_rdata  (rdata),
    .io_slave_rlast  (rlast),
    .io_slave_rid    (rid)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic [3:0]  id;
  } r_exp_t;

  typedef struct packed {
    logic [1:0] resp;
    logic [3:0] id;
  } b_exp_t;

  r_exp_t r_q[$];
  b_exp_t b_q[$];
  r_exp_t mon_r;
  b_exp_t mon_b;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Response monitor (samples 1 time unit after the falling edge, after the
  // stimulus has settled its inputs for the coming rising edge)
  // ---------------------------------------------------------------------------
  always @(negedge clock) begin
    #1;
    if (!reset && rvalid && rready) begin
      check("r_rlast", {31'd0, rlast}, 32'd1);
      if (r_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL r_unexpected: got rid=%h rdata=%h expected no response", rid, rdata);
      end else begin
        mon_r = r_q.pop_front();
        check("r_data", rdata, mon_r.data);
        check("r_resp", {30'd0, rresp}, {30'd0, mon_r.resp});
        check("r_id", {28'd0, rid}, {28'd0, mon_r.id});
        $display("R  id=%0d resp=%b data=%h", rid, rresp, rdata);
      end
    end
    if (!reset && bvalid && bready) begin
      if (b_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b_unexpected: got bid=%h bresp=%b expected no response", bid, bresp);
      end else begin
        mon_b = b_q.pop_front();
        check("b_resp", {30'd0, bresp}, {30'd0, mon_b.resp});
        check("b_id", {28'd0, bid}, {28'd0, mon_b.id});
        $display("B  id=%0d resp=%b", bid, bresp);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus tasks
  // ---------------------------------------------------------------------------
  task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic [31:0] exp_data, input logic [1:0] exp_resp, input int hold);
    r_exp_t e;
    int     n;
    e.data = exp_data;
    e.resp = exp_resp;
    e.id   = id;
    r_q.push_back(e);
    @(negedge clock);
    arvalid = 1'b1;
    araddr  = addr;
    arid    = id;
    arlen   = len;
    rready  = (hold == 0);
    n = 0;
    while (!arready && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("ar_accept", {31'd0, arready}, 32'd1);
    @(negedge clock);
    arvalid = 1'b0;
    arlen   = 8'd0;
    n = 0;
    while (!rvalid && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("r_latency", n, 1 + RD_LAT);
    for (int i = 0; i < hold; i++) begin
      check("r_hold_valid", {31'd0, rvalid}, 32'd1);
      check("r_hold_data", rdata, exp_data);
      check("r_hold_id", {28'd0, rid}, {28'd0, id});
      check("r_hold_arready", {31'd0, arready}, 32'd0);
      @(negedge clock);
    end
    rready = 1'b1;
    @(negedge clock);
    check("r_done_arready", {31'd0, arready}, 32'd1);
    check("r_done_rvalid", {31'd0, rvalid}, 32'd0);
    rready = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] exp_resp);
    b_exp_t e;
    int     n;
    e.resp = exp_resp;
    e.id   = id;
    b_q.push_back(e);
    @(negedge clock);
    awvalid = 1'b1;
    awaddr  = addr;
    awid    = id;
    awlen   = 8'd0;
    bready  = 1'b1;
    n = 0;
    while (!awready && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("aw_accept", {31'd0, awready}, 32'd1);
    check("w_idle_wready", {31'd0, wready}, 32'd0);
    @(negedge clock);
    awvalid = 1'b0;
    wvalid  = 1'b1;
    wdata   = data;
    wstrb   = strb;
    check("w_accept", {31'd0, wready}, 32'd1);
    @(negedge clock);
    wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("b_latency", n, 1 + WR_LAT);
    @(negedge clock);
    check("b_done_awready", {31'd0, awready}, 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    r_exp_t re;
    b_exp_t be;
    int     n;

    awvalid = 1'b0; awaddr = '0; awid = '0; awlen = '0; awsize = 3'd2; awburst = 2'd1;
    wvalid  = 1'b0; wdata  = '0; wstrb = '0; wlast = 1'b1; bready = 1'b0;
    arvalid = 1'b0; araddr = '0; arid = '0; arlen = '0; arsize = 3'd2; arburst = 2'd1;
    rready  = 1'b0;

    // Reset: outputs low while held, idle handshake state after release.
    repeat (2) @(negedge clock);
    check("rst_arready", {31'd0, arready}, 32'd0);
    check("rst_awready", {31'd0, awready}, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_arready", {31'd0, arready}, 32'd1);
    check("post_rst_awready", {31'd0, awready}, 32'd1);
    check("post_rst_wready", {31'd0, wready}, 32'd0);
    check("post_rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("post_rst_bvalid", {31'd0, bvalid}, 32'd0);
    check("post_rst_rdata", rdata, 32'd0);

    // Preload word 0 and read it back.
    do_write(BASE, 4'd1, 32'hDEADBEEF, 4'hF, 2'b00);
    do_read(BASE, 4'd3, 8'd0, 32'hDEADBEEF, 2'b00, 0);

    // Partial-strobe write into a cleared word 1.
    do_write(BASE + 32'd4, 4'd2, 32'h0000_0000, 4'hF, 2'b00);
    do_write(BASE + 32'd4, 4'd4, 32'h1122_3344, 4'b0110, 2'b00);
    do_read(BASE + 32'd4, 4'd4, 8'd0, 32'h0022_3300, 2'b00, 0);
    // Low address bits are ignored.
    do_read(BASE + 32'd6, 4'd7, 8'd0, 32'h0022_3300, 2'b00, 0);

    // Out-of-range and non-single-beat accesses.
    do_read(32'h7FFF_FFFC, 4'd5, 8'd0, 32'd0, 2'b11, 0);
    do_write(BASE + 32'(4 * DEPTH), 4'd6, 32'hA5A5_A5A5, 4'hF, 2'b11);
    do_read(BASE, 4'd8, 8'd0, 32'hDEADBEEF, 2'b00, 0);
    do_read(BASE, 4'd6, 8'd1, 32'd0, 2'b11, 0);

    // Last word of the window.
    do_write(BASE + 32'(4 * DEPTH - 4), 4'd11, 32'hCAFE_F00D, 4'hF, 2'b00);
    do_read(BASE + 32'(4 * DEPTH - 4), 4'd12, 8'd0, 32'hCAFE_F00D, 2'b00, 0);

    // Back-pressure on R for 5 cycles.
    do_read(BASE, 4'd13, 8'd0, 32'hDEADBEEF, 2'b00, 5);

    // Same-edge read capture and write commit on word 8.
    do_write(BASE + 32'h20, 4'd14, 32'h0BAD_F00D, 4'hF, 2'b00);
    be.resp = 2'b00; be.id = 4'd9;
    b_q.push_back(be);
    re.data = 32'h0BAD_F00D; re.resp = 2'b00; re.id = 4'd10;
    r_q.push_back(re);
    @(negedge clock);
    check("coll_awready", {31'd0, awready}, 32'd1);
    check("coll_arready", {31'd0, arready}, 32'd1);
    awvalid = 1'b1; awaddr = BASE + 32'h20; awid = 4'd9; bready = 1'b1; rready = 1'b1;
    @(negedge clock);
    awvalid = 1'b0;
    arvalid = 1'b1; araddr = BASE + 32'h20; arid = 4'd10; arlen = 8'd0;
    @(negedge clock);
    arvalid = 1'b0;
    @(negedge clock);
    wvalid = 1'b1; wdata = 32'h600D_CAFE; wstrb = 4'hF;
    @(negedge clock);
    wvalid = 1'b0;
    n = 0;
    while ((r_q.size() != 0 || b_q.size() != 0) && n < 40) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    check("coll_drain", r_q.size() + b_q.size(), 32'd0);
    rready = 1'b0;
    do_read(BASE + 32'h20, 4'd15, 8'd0, 32'h600D_CAFE, 2'b00, 0);

    // Reset while the write channel is counting down: response dropped.
    @(negedge clock);
    awvalid = 1'b1; awaddr = BASE + 32'h40; awid = 4'd2; bready = 1'b1;
    @(negedge clock);
    awvalid = 1'b0; wvalid = 1'b1; wdata = 32'h1357_9BDF; wstrb = 4'hF;
    @(negedge clock);
    wvalid = 1'b0;
    reset  = 1'b1;
    #1;
    check("midrst_awready", {31'd0, awready}, 32'd0);
    check("midrst_bvalid", {31'd0, bvalid}, 32'd0);
    check("midrst_arready", {31'd0, arready}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("midrst_rel_awready", {31'd0, awready}, 32'd1);
    check("midrst_rel_arready", {31'd0, arready}, 32'd1);
    check("midrst_rel_bvalid", {31'd0, bvalid}, 32'd0);
    repeat (4) begin
      @(negedge clock);
      check("midrst_no_bvalid", {31'd0, bvalid}, 32'd0);
    end
    do_read(BASE, 4'd1, 8'd0, 32'hDEADBEEF, 2'b00, 0);
    do_read(BASE + 32'd4, 4'd2, 8'd0, 32'h0022_3300, 2'b00, 0);
    do_read(BASE + 32'h20, 4'd3, 8'd0, 32'h600D_CAFE, 2'b00, 0);

    repeat (3) @(negedge clock);
    check("final_queues_empty", r_q.size() + b_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
